// File: rtl/cache_dm.sv
// cache_dm: parametrised direct-mapped write-through cache between a
// pipeline stage and a RAM with a request/acknowledge handshake.
// Ports:
//   g_clk, g_clr              clock, async active-high reset
//   addr, wdata, rd, wr       CPU request (sampled when accepted in IDLE)
//   flush                     invalidate all lines (IDLE only)
//   rdata, odv, busy          CPU response, one-cycle odv pulse, not-IDLE flag
//   ram_addr, ram_wdata       RAM request payload
//   ram_rd, ram_wr, ram_ack   RAM handshake, requests held until ram_ack
//   ram_rdata                 RAM read data, valid with ram_ack
//   hit_cnt, miss_cnt         wrapping read hit/miss counters
module cache_dm #(
   parameter int unsigned d_width   = 8,
   parameter int unsigned a_width   = 8,
   parameter int unsigned lines     = 4,
   parameter int unsigned cnt_width = 16
) (
   input  logic                 g_clk,
   input  logic                 g_clr,
   input  logic [a_width-1:0]   addr,
   input  logic [d_width-1:0]   wdata,
   input  logic                 rd,
   input  logic                 wr,
   input  logic                 flush,
   output logic [d_width-1:0]   rdata,
   output logic                 odv,
   output logic                 busy,
   output logic [a_width-1:0]   ram_addr,
   output logic [d_width-1:0]   ram_wdata,
   output logic                 ram_rd,
   output logic                 ram_wr,
   input  logic [d_width-1:0]   ram_rdata,
   input  logic                 ram_ack,
   output logic [cnt_width-1:0] hit_cnt,
   output logic [cnt_width-1:0] miss_cnt
);

   localparam int unsigned idx_w = $clog2(lines);
   localparam int unsigned tag_w = a_width - idx_w;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t state, state_d;

   logic [lines-1:0]   valid_q;
   logic [tag_w-1:0]   tag_q  [lines];
   logic [d_width-1:0] data_q [lines];

   logic [d_width-1:0]   rdata_d;
   logic                 odv_d;
   logic [a_width-1:0]   ram_addr_d;
   logic [d_width-1:0]   ram_wdata_d;
   logic                 ram_rd_d;
   logic                 ram_wr_d;
   logic [cnt_width-1:0] hit_cnt_d;
   logic [cnt_width-1:0] miss_cnt_d;

   logic                 line_we;
   logic [idx_w-1:0]     line_idx;
   logic [tag_w-1:0]     line_tag;
   logic [d_width-1:0]   line_data;
   logic                 valid_set;
   logic                 valid_clr_all;

   logic [idx_w-1:0]     req_idx;
   logic [tag_w-1:0]     req_tag;
   logic                 req_hit;

   // Lookup of the CPU address against the addressed line
   assign req_idx = addr[idx_w-1:0];
   assign req_tag = addr[a_width-1:idx_w];
   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // Next-state, next-output and line-update decode
   always_comb begin
      state_d       = state;
      rdata_d       = rdata;
      odv_d         = 1'b0;
      ram_addr_d    = ram_addr;
      ram_wdata_d   = ram_wdata;
      ram_rd_d      = ram_rd;
      ram_wr_d      = ram_wr;
      hit_cnt_d     = hit_cnt;
      miss_cnt_d    = miss_cnt;
      line_we       = 1'b0;
      line_idx      = req_idx;
      line_tag      = req_tag;
      line_data     = wdata;
      valid_set     = 1'b0;
      valid_clr_all = 1'b0;

      unique case (state)
         IDLE: begin
            if (flush) begin
               valid_clr_all = 1'b1;
            end else if (wr) begin
               // Write-through without allocate: only refresh a line already present
               line_we     = req_hit;
               ram_addr_d  = addr;
               ram_wdata_d = wdata;
               ram_wr_d    = 1'b1;
               state_d     = WRITE;
            end else if (rd) begin
               if (req_hit) begin
                  rdata_d   = data_q[req_idx];
                  odv_d     = 1'b1;
                  hit_cnt_d = hit_cnt + cnt_width'(1);
               end else begin
                  ram_addr_d = addr;
                  ram_rd_d   = 1'b1;
                  miss_cnt_d = miss_cnt + cnt_width'(1);
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            // The latched address lives in ram_addr for the whole fill
            line_idx  = ram_addr[idx_w-1:0];
            line_tag  = ram_addr[a_width-1:idx_w];
            line_data = ram_rdata;
            if (ram_ack) begin
               line_we   = 1'b1;
               valid_set = 1'b1;
               rdata_d   = ram_rdata;
               odv_d     = 1'b1;
               ram_rd_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         WRITE: begin
            if (ram_ack) begin
               odv_d    = 1'b1;
               ram_wr_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, registered outputs and valid bits
   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr) begin
         state     <= IDLE;
         rdata     <= '0;
         odv       <= 1'b0;
         busy      <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_rd    <= 1'b0;
         ram_wr    <= 1'b0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         valid_q   <= '0;
      end else begin
         state     <= state_d;
         rdata     <= rdata_d;
         odv       <= odv_d;
         busy      <= (state_d != IDLE);
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         ram_rd    <= ram_rd_d;
         ram_wr    <= ram_wr_d;
         hit_cnt   <= hit_cnt_d;
         miss_cnt  <= miss_cnt_d;
         if (valid_clr_all) begin
            valid_q <= '0;
         end else if (valid_set) begin
            valid_q[line_idx] <= 1'b1;
         end
      end
   end

   // Tag and data storage; contents are qualified by valid_q, so no reset
   always_ff @(posedge g_clk) begin
      if (line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_data;
      end
   end

endmodule
